zx_spi_txq: RTL and testbench
=============================

# zx_spi_txq

Byte queue and transfer sequencer between the Z80 I/O port logic and the SPI shift registers. CPU writes to the SPI data port go into a transmit FIFO, so block `OUTI`/`OTIR` bursts need no busy polling. The sequencer hands one byte at a time to the shifter and stores each received byte in a receive FIFO that CPU reads pop. It replaces direct CPU-to-shifter loading on the data port; the config port is unaffected.

## Interface
Parameters:
- `DEPTH_LOG2`, 3, log2 of each FIFO depth (DEPTH = 8)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `reset_L`  in  1  synchronous, active-low reset
- `cpu_wr`  in  1  one-cycle strobe: push `cpu_din` into TX FIFO
- `cpu_din`  in  8  write data from Z80 bus
- `cpu_rd`  in  1  one-cycle strobe: pop RX FIFO head
- `cpu_dout`  out  8  RX FIFO head (combinational from storage); 0x00 when RX empty
- `rx_enable`  in  1  1 = keep received bytes; 0 = discard (write-only streams)
- `clr_err`  in  1  one-cycle strobe: clear sticky error flags
- `tx_empty`, `tx_full`, `rx_empty`, `rx_full`  out  1 each  FIFO status
- `tx_level`  out  DEPTH_LOG2+1  TX occupancy, 0..DEPTH
- `tx_ovf`  out  1  sticky: write dropped while TX full
- `rx_unf`  out  1  sticky: pop attempted while RX empty
- `xfer_active`  out  1  sequencer not in IDLE, or TX non-empty
- `shift_load`  out  1  one-cycle pulse: shifter loads `shift_data` and starts
- `shift_data`  out  8  byte for shifter; held from LOAD until the next LOAD
- `shift_busy`  in  1  shifter busy; high for the whole 8-bit transfer
- `shift_rx`  in  8  shifter receive byte; valid when `shift_busy` falls

## Operation
- FIFOs: circular buffers. Read/write pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. Counts are DEPTH_LOG2+1 bits.
- TX push: `cpu_wr` with TX count < DEPTH writes at the write pointer.
  - Fullness is judged on the pre-edge count. A write while full is dropped and sets `tx_ovf`, even if the sequencer pops in the same cycle.
- RX pop: `cpu_rd` with RX non-empty advances the read pointer. On empty, no state change and `rx_unf` is set.
  - A push and a pop in the same cycle leave the count unchanged.
- `clr_err` clears `tx_ovf` and `rx_unf`. If a new error occurs in the same cycle, the set wins.
- Sequencer states:
  - IDLE: go to LOAD when TX is non-empty and (the `rx_enable` value sampled now is 0, or RX count < DEPTH).
  - LOAD:
    - `shift_load`=1 for this cycle only.
    - Register `shift_data` from the TX head and pop TX.
    - Latch `rx_enable` into `keep_rx`.
    - Go to WAIT_BUSY.
  - WAIT_BUSY: go to SHIFT when `shift_busy`=1. No timeout.
  - SHIFT: go to CAPTURE when `shift_busy`=0.
  - CAPTURE:
    - If `keep_rx`, push `shift_rx` into RX.
    - Then apply the IDLE entry condition: go directly to LOAD if it holds, otherwise to IDLE.
- RX is never overrun: the IDLE/CAPTURE check reserves the slot before LOAD, and only the sequencer pushes RX.
- Changing `rx_enable` mid-transfer has no effect until the next LOAD.

## Timing
- Reset (`reset_L`=0 at an edge) produces:
  - all pointers and counts at 0, state IDLE;
  - `shift_load`=0, `shift_data`=0x00;
  - `tx_empty`=`rx_empty`=1, `tx_full`=`rx_full`=0, `tx_level`=0;
  - `tx_ovf`=`rx_unf`=0, `xfer_active`=0, `cpu_dout`=0x00.
- Reset mid-transfer aborts immediately and discards both FIFOs. The shifter must be reset by the same `reset_L`.
- Status outputs are registered; they reflect an edge's push/pop from the following cycle.
- Latency, TX empty and IDLE:
  - `cpu_wr` sampled at edge n gives `tx_empty`=0 after n.
  - IDLE→LOAD at edge n+1.
  - `shift_load`=1 and `shift_data` valid during the cycle after n+1.
  - `tx_empty` returns to 1 after edge n+2.
- Back-to-back: after `shift_busy` falls, CAPTURE takes one cycle. The next `shift_load` follows CAPTURE with no IDLE cycle, giving 2 cycles of overhead per byte plus WAIT_BUSY.
- An RX byte is visible on `cpu_dout` the cycle after the CAPTURE edge.
- `shift_busy` already high when WAIT_BUSY is entered moves to SHIFT on that same edge.

## Test plan
- Reset: hold `reset_L`=0 with strobes active → all outputs at the reset values above; release → no `shift_load` for 10 cycles.
- Single byte: write 0xA5 with `rx_enable`=1; shifter model busy 16 cycles returning 0x3C → exactly one `shift_load` with `shift_data`=0xA5 two cycles after write; `cpu_dout`=0x3C and `rx_empty`=0 after CAPTURE.
- Burst with wrap: write 8 bytes 0x00..0x07 (`tx_full`=1), then a 9th (0xFF) → `tx_ovf`=1, 0xFF never loaded; loads occur in order 0x00..0x07. Repeat with 12 more bytes → pointer wrap preserves order.
- RX backpressure: `rx_enable`=1, push 10 bytes, never read → exactly 8 transfers, sequencer stalls in IDLE with `rx_full`=1; one `cpu_rd` → 9th transfer starts; after two more pops the 10th completes.
- Discard mode: `rx_enable`=0, 10 bytes → 10 transfers, `rx_empty` stays 1. `cpu_rd` → `rx_unf`=1, `cpu_dout`=0x00. `clr_err` → cleared.
- Simultaneity and abort:
  - `cpu_wr` while full in the same cycle as LOAD's pop → write dropped, `tx_ovf`=1.
  - `clr_err` with a new underflow → `rx_unf` stays 1.
  - `reset_L`=0 in SHIFT → IDLE, FIFOs empty next cycle.

Source files
------------

// File: rtl/zx_spi_txq.sv
`timescale 1ns/1ps
// zx_spi_txq: TX/RX byte FIFOs between the Z80 data port and the SPI shifter, plus a
// sequencer that loads one TX byte at a time and collects each received byte.
module zx_spi_txq #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  cpu_wr,
    input  logic [7:0]            cpu_din,
    input  logic                  cpu_rd,
    output logic [7:0]            cpu_dout,
    input  logic                  rx_enable,
    input  logic                  clr_err,
    output logic                  tx_empty,
    output logic                  tx_full,
    output logic                  rx_empty,
    output logic                  rx_full,
    output logic [DEPTH_LOG2:0]   tx_level,
    output logic                  tx_ovf,
    output logic                  rx_unf,
    output logic                  xfer_active,
    output logic                  shift_load,
    output logic [7:0]            shift_data,
    input  logic                  shift_busy,
    input  logic [7:0]            shift_rx
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_SHIFT, S_CAPT} state_t;

    state_t                r_state;
    logic [7:0]            r_tx_mem [DEPTH];
    logic [7:0]            r_rx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic [DEPTH_LOG2:0]   r_tx_cnt, r_rx_cnt;
    logic                  r_keep_rx, r_tx_ovf, r_rx_unf, r_shift_load;
    logic [7:0]            r_shift_data;
    logic                  w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_go;
    logic [DEPTH_LOG2:0]   w_rx_cnt_nxt;

    assign w_tx_push    = cpu_wr && r_tx_cnt != FULL;
    assign w_tx_pop     = r_state == S_LOAD;
    assign w_rx_push    = r_state == S_CAPT && r_keep_rx;
    assign w_rx_pop     = cpu_rd && r_rx_cnt != '0;
    assign w_rx_cnt_nxt = r_rx_cnt + (DEPTH_LOG2+1)'(w_rx_push) - (DEPTH_LOG2+1)'(w_rx_pop);
    // RX fullness is judged after this edge's push so a CAPTURE->LOAD hop can never overrun RX
    assign w_go         = r_tx_cnt != '0 && (!rx_enable || w_rx_cnt_nxt != FULL);

    assign cpu_dout    = (r_rx_cnt == '0) ? 8'h00 : r_rx_mem[r_rx_rp];
    assign tx_empty    = r_tx_cnt == '0;
    assign tx_full     = r_tx_cnt == FULL;
    assign rx_empty    = r_rx_cnt == '0;
    assign rx_full     = r_rx_cnt == FULL;
    assign tx_level    = r_tx_cnt;
    assign tx_ovf      = r_tx_ovf;
    assign rx_unf      = r_rx_unf;
    assign xfer_active = r_state != S_IDLE || r_tx_cnt != '0;
    assign shift_load  = r_shift_load;
    assign shift_data  = r_shift_data;

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp] <= cpu_din;
        if (w_rx_push) r_rx_mem[r_rx_wp] <= shift_rx;
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_state      <= S_IDLE;
            r_tx_wp      <= '0;
            r_tx_rp      <= '0;
            r_rx_wp      <= '0;
            r_rx_rp      <= '0;
            r_tx_cnt     <= '0;
            r_rx_cnt     <= '0;
            r_keep_rx    <= 1'b0;
            r_tx_ovf     <= 1'b0;
            r_rx_unf     <= 1'b0;
            r_shift_load <= 1'b0;
            r_shift_data <= 8'h00;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + DEPTH_LOG2'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + DEPTH_LOG2'(1);
            if (w_rx_push) r_rx_wp <= r_rx_wp + DEPTH_LOG2'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + DEPTH_LOG2'(1);
            r_tx_cnt     <= r_tx_cnt + (DEPTH_LOG2+1)'(w_tx_push) - (DEPTH_LOG2+1)'(w_tx_pop);
            r_rx_cnt     <= w_rx_cnt_nxt;
            r_tx_ovf     <= (cpu_wr && r_tx_cnt == FULL) || (r_tx_ovf && !clr_err);
            r_rx_unf     <= (cpu_rd && r_rx_cnt == '0) || (r_rx_unf && !clr_err);
            r_shift_load <= 1'b0;
            if ((r_state == S_IDLE || r_state == S_CAPT) && w_go) begin
                r_state      <= S_LOAD;
                r_shift_load <= 1'b1;
                r_shift_data <= r_tx_mem[r_tx_rp];
                r_keep_rx    <= rx_enable;
            end else begin
                case (r_state)
                    S_LOAD:  r_state <= S_WAIT;
                    S_WAIT:  r_state <= shift_busy ? S_SHIFT : S_WAIT;
                    S_SHIFT: r_state <= shift_busy ? S_SHIFT : S_CAPT;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_zx_spi_txq.sv
`timescale 1ns/1ps
// tb_zx_spi_txq: directed, table-driven and randomized checks of the SPI TX/RX queue
// against a queue-based model and a simple behavioural shifter.
module tb_zx_spi_txq;
    logic       clk = 1'b0;
    logic       reset_L = 1'b0;
    logic       cpu_wr = 1'b0, cpu_rd = 1'b0, rx_enable = 1'b0, clr_err = 1'b0;
    logic [7:0] cpu_din = 8'h00;
    logic       shift_busy = 1'b0;
    logic [7:0] shift_rx = 8'h00;
    logic [7:0] cpu_dout, shift_data;
    logic       tx_empty, tx_full, rx_empty, rx_full, tx_ovf, rx_unf, xfer_active, shift_load;
    logic [3:0] tx_level;

    zx_spi_txq #(.DEPTH_LOG2(3)) dut (
        .clk(clk), .reset_L(reset_L), .cpu_wr(cpu_wr), .cpu_din(cpu_din), .cpu_rd(cpu_rd),
        .cpu_dout(cpu_dout), .rx_enable(rx_enable), .clr_err(clr_err),
        .tx_empty(tx_empty), .tx_full(tx_full), .rx_empty(rx_empty), .rx_full(rx_full),
        .tx_level(tx_level), .tx_ovf(tx_ovf), .rx_unf(rx_unf), .xfer_active(xfer_active),
        .shift_load(shift_load), .shift_data(shift_data), .shift_busy(shift_busy),
        .shift_rx(shift_rx)
    );

    always #5 clk = ~clk;

    int         n_cmp = 0, n_bad = 0;
    logic [7:0] load_log[$], exp_loads[$], exp_rx[$];
    int         busy_len = 4;
    bit         rand_busy = 1'b0;
    int         sh_cnt = 0;
    logic [7:0] sh_val = 8'h00;

    // Shifter: busy for a number of negedges after each load, returns byte ^ 0x99
    always @(negedge clk) begin
        if (!reset_L) begin
            sh_cnt = 0;
            shift_busy = 1'b0;
        end else if (shift_load) begin
            load_log.push_back(shift_data);
            sh_cnt = rand_busy ? int'($urandom_range(2, 7)) : busy_len;
            shift_busy = 1'b1;
            sh_val = shift_data ^ 8'h99;
        end else if (sh_cnt > 0) begin
            sh_cnt--;
            if (sh_cnt == 0) begin
                shift_busy = 1'b0;
                shift_rx = sh_val;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        cpu_wr = 1'b1;
        cpu_din = b;
        tick();
        cpu_wr = 1'b0;
    endtask

    task automatic clr();
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
    endtask

    task automatic rd_chk(input string nm);
        logic [7:0] e;
        e = exp_rx.pop_front();
        chk(nm, cpu_dout, e);
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        int k = 0;
        while ((xfer_active || shift_busy) && k < budget) begin
            tick();
            k++;
        end
        chk({nm, "_idle_timeout"}, k < budget, 1);
    endtask

    task automatic cmp_loads(input string nm);
        chk({nm, "_load_count"}, load_log.size(), exp_loads.size());
        for (int i = 0; i < load_log.size() && i < exp_loads.size(); i++)
            chk($sformatf("%s_load%0d", nm, i), load_log[i], exp_loads[i]);
        load_log.delete();
        exp_loads.delete();
    endtask

    typedef struct {
        logic rd;
        logic clr;
        logic exp_unf;
    } vec_t;

    initial begin
        vec_t tbl[6];
        int k;
        int m_tx;
        logic m_ovf, acc, sl;
        tbl[0] = '{1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 1'b1, 1'b0};

        // Reset held with strobes active
        #1;
        cpu_wr = 1'b1; cpu_rd = 1'b1; clr_err = 1'b1; cpu_din = 8'h55;
        repeat (3) tick();
        chk("rst_tx_empty", tx_empty, 1);
        chk("rst_rx_empty", rx_empty, 1);
        chk("rst_tx_full", tx_full, 0);
        chk("rst_rx_full", rx_full, 0);
        chk("rst_tx_level", tx_level, 0);
        chk("rst_tx_ovf", tx_ovf, 0);
        chk("rst_rx_unf", rx_unf, 0);
        chk("rst_xfer_active", xfer_active, 0);
        chk("rst_cpu_dout", cpu_dout, 8'h00);
        chk("rst_shift_load", shift_load, 0);
        chk("rst_shift_data", shift_data, 8'h00);
        cpu_wr = 1'b0; cpu_rd = 1'b0; clr_err = 1'b0; reset_L = 1'b1;
        repeat (10) tick();
        chk("rst_no_load", load_log.size(), 0);

        // Underflow / clear table on an empty RX
        for (int i = 0; i < 6; i++) begin
            cpu_rd = tbl[i].rd;
            clr_err = tbl[i].clr;
            tick();
            cpu_rd = 1'b0;
            clr_err = 1'b0;
            chk($sformatf("tbl%0d_rx_unf", i), rx_unf, tbl[i].exp_unf);
            chk($sformatf("tbl%0d_cpu_dout", i), cpu_dout, 8'h00);
        end

        // Single byte, latency
        rx_enable = 1'b1;
        busy_len = 16;
        exp_loads.push_back(8'hA5);
        exp_rx.push_back(8'h3C);
        wr(8'hA5);
        chk("single_tx_empty_after_wr", tx_empty, 0);
        chk("single_no_load_yet", shift_load, 0);
        tick();
        chk("single_shift_load", shift_load, 1);
        chk("single_shift_data", shift_data, 8'hA5);
        chk("single_xfer_active", xfer_active, 1);
        tick();
        chk("single_tx_empty_after_pop", tx_empty, 1);
        chk("single_load_pulse_end", shift_load, 0);
        k = 0;
        while (rx_empty && k < 60) begin tick(); k++; end
        chk("single_rx_timeout", k < 60, 1);
        chk("single_cpu_dout", cpu_dout, 8'h3C);
        wait_idle("single", 20);
        cmp_loads("single");
        rd_chk("single_rd");
        chk("single_rx_empty_after_rd", rx_empty, 1);

        // Burst: fill TX behind a slow transfer, overflow, then drop during LOAD's pop
        rx_enable = 1'b0;
        busy_len = 40;
        wr(8'h00);
        exp_loads.push_back(8'h00);
        repeat (3) tick();
        for (int i = 1; i <= 8; i++) begin
            wr(8'(i));
            exp_loads.push_back(8'(i));
        end
        chk("burst_tx_full", tx_full, 1);
        chk("burst_tx_level", tx_level, 8);
        wr(8'hFF);
        chk("burst_tx_ovf", tx_ovf, 1);
        chk("burst_level_after_drop", tx_level, 8);
        clr();
        chk("burst_ovf_cleared", tx_ovf, 0);
        k = 0;
        while (!shift_load && k < 100) begin tick(); k++; end
        chk("burst_load_timeout", k < 100, 1);
        busy_len = 3;
        wr(8'hEE);
        chk("simul_pop_ovf", tx_ovf, 1);
        chk("simul_pop_level", tx_level, 7);
        wait_idle("burst", 300);
        cmp_loads("burst");
        clr();
        for (int g = 0; g < 2; g++) begin
            for (int i = 0; i < 6; i++) begin
                wr(8'(8'h10 + g * 6 + i));
                exp_loads.push_back(8'(8'h10 + g * 6 + i));
            end
            wait_idle("wrap", 200);
        end
        chk("wrap_no_ovf", tx_ovf, 0);
        cmp_loads("wrap");

        // RX backpressure
        rx_enable = 1'b1;
        busy_len = 2;
        for (int i = 0; i < 10; i++) begin
            wr(8'(8'h20 + i));
            exp_loads.push_back(8'(8'h20 + i));
            exp_rx.push_back(8'(8'h20 + i) ^ 8'h99);
        end
        repeat (60) tick();
        chk("bp_loads_stalled", load_log.size(), 8);
        chk("bp_rx_full", rx_full, 1);
        chk("bp_tx_level", tx_level, 2);
        chk("bp_xfer_active", xfer_active, 1);
        rd_chk("bp_rd0");
        k = 0;
        while (load_log.size() < 9 && k < 30) begin tick(); k++; end
        chk("bp_ninth_timeout", k < 30, 1);
        repeat (10) tick();
        chk("bp_tenth_stalled", load_log.size(), 9);
        chk("bp_rx_full_again", rx_full, 1);
        rd_chk("bp_rd1");
        rd_chk("bp_rd2");
        wait_idle("bp", 50);
        cmp_loads("bp");
        k = 0;
        while (exp_rx.size() > 0 && k < 20) begin rd_chk("bp_drain"); k++; end
        chk("bp_rx_empty", rx_empty, 1);

        // Discard mode
        rx_enable = 1'b0;
        busy_len = 3;
        for (int i = 0; i < 10; i++) begin
            wr(8'(8'h40 + i));
            exp_loads.push_back(8'(8'h40 + i));
        end
        wait_idle("discard", 200);
        cmp_loads("discard");
        chk("discard_rx_empty", rx_empty, 1);
        cpu_rd = 1'b1;
        tick();
        cpu_rd = 1'b0;
        chk("discard_rx_unf", rx_unf, 1);
        chk("discard_cpu_dout", cpu_dout, 8'h00);
        clr();
        chk("discard_unf_cleared", rx_unf, 0);

        // Reset during SHIFT
        rx_enable = 1'b1;
        busy_len = 30;
        wr(8'h60);
        wr(8'h61);
        wr(8'h62);
        repeat (2) tick();
        chk("abort_in_shift", shift_busy, 1);
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
        chk("abort_tx_empty", tx_empty, 1);
        chk("abort_rx_empty", rx_empty, 1);
        chk("abort_tx_level", tx_level, 0);
        chk("abort_xfer_active", xfer_active, 0);
        chk("abort_shift_data", shift_data, 8'h00);
        load_log.delete();
        exp_loads.delete();
        exp_rx.delete();
        repeat (10) tick();
        chk("abort_no_load", load_log.size(), 0);

        // Randomized traffic against the queue model
        rand_busy = 1'b1;
        rx_enable = 1'b1;
        m_tx = 0;
        m_ovf = 1'b0;
        for (int c = 0; c < 800; c++) begin
            cpu_wr = ($urandom % 3) == 0;
            cpu_rd = ($urandom % 4) == 0;
            clr_err = ($urandom % 16) == 0;
            cpu_din = 8'($urandom);
            sl = shift_load;
            acc = cpu_wr && m_tx < 8;
            if (acc) begin
                exp_loads.push_back(cpu_din);
                exp_rx.push_back(cpu_din ^ 8'h99);
            end
            if (cpu_rd && !rx_empty) begin
                if (exp_rx.size() == 0) chk("rnd_rx_extra", exp_rx.size(), 1);
                else chk("rnd_rd", cpu_dout, exp_rx.pop_front());
            end
            m_tx = m_tx + int'(acc) - int'(sl);
            m_ovf = (cpu_wr && !acc) || (m_ovf && !clr_err);
            tick();
            chk("rnd_tx_level", tx_level, m_tx);
            chk("rnd_tx_full", tx_full, m_tx == 8);
            chk("rnd_tx_ovf", tx_ovf, m_ovf);
        end
        cpu_wr = 1'b0;
        cpu_rd = 1'b0;
        clr_err = 1'b0;
        k = 0;
        while ((xfer_active || shift_busy || exp_rx.size() > 0) && k < 2000) begin
            if (!rx_empty && exp_rx.size() > 0) rd_chk("rnd_drain");
            else tick();
            k++;
        end
        chk("rnd_drain_timeout", k < 2000, 1);
        cmp_loads("rnd");
        chk("rnd_rx_empty", rx_empty, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
